// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST sequencer: FSM encoding, LFSR/MISR
// polynomial, ALUOp sizing and the Galois step helper.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, Galois form
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned OP_COUNT  = 32;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// 32-bit Galois LFSR register with synchronous load, step enable and a
// data term XORed into the step (data tied to zero gives a plain LFSR).
module alu_bist_lfsr
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] value
);

  logic [31:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      value_d = lfsr_step(value_q) ^ data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/alu_bist.sv
// ALU BIST sequencer: sweeps all ALUOp codes with LFSR operands and folds the
// responses into a MISR. Optional abort input under `ALU_BIST_ABORT_EN.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_1234,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef ALU_BIST_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [31:0]     signature,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [31:0]     alu_c,
  input  logic            alu_zero
);

  localparam int unsigned CNT_W    = $clog2(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VECTORS - 1);
  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(OP_COUNT - 1);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [31:0]      sig_q, sig_d;

  logic        opnd_load, opnd_en, misr_load, misr_en, seed_sel;
  logic [31:0] a_load_val, b_load_val;
  logic [31:0] misr_q, misr_data, misr_next;
  logic        last_vec;

  // Response is sampled the same cycle its vector is presented (ALU is combinational)
  assign misr_data = alu_c ^ {31'b0, alu_zero};
  assign misr_next = lfsr_step(misr_q) ^ misr_data;
  assign last_vec  = (op_q == OP_LAST) && (cnt_q == CNT_LAST);
  assign a_load_val = seed_sel ? LFSR_SEED  : '0;
  assign b_load_val = seed_sel ? ~LFSR_SEED : '0;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    sig_d     = sig_q;
    opnd_load = 1'b0;
    opnd_en   = 1'b0;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    seed_sel  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          opnd_load = 1'b1;
          seed_sel  = 1'b1;
          misr_load = 1'b1;
          op_d      = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      RUN: begin
`ifdef ALU_BIST_ABORT_EN
        if (abort) begin
          state_d   = IDLE;
          opnd_load = 1'b1;
          op_d      = '0;
          cnt_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end else
`endif
        begin
          opnd_en = 1'b1;
          misr_en = 1'b1;
          if (last_vec) begin
            state_d   = DONE;
            sig_d     = misr_next;
            pass_d    = (misr_next == GOLDEN_SIG);
            done_d    = 1'b1;
            busy_d    = 1'b0;
            opnd_load = 1'b1;
            op_d      = '0;
            cnt_d     = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            op_d  = op_q + OP_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  alu_bist_lfsr u_lfsr_a (
    .clk      (clk),
    .rst      (rst),
    .load     (opnd_load),
    .load_val (a_load_val),
    .en       (opnd_en),
    .data     ('0),
    .value    (alu_a)
  );

  alu_bist_lfsr u_lfsr_b (
    .clk      (clk),
    .rst      (rst),
    .load     (opnd_load),
    .load_val (b_load_val),
    .en       (opnd_en),
    .data     ('0),
    .value    (alu_b)
  );

  alu_bist_lfsr u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (misr_load),
    .load_val ('0),
    .en       (misr_en),
    .data     (misr_data),
    .value    (misr_q)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign alu_op    = op_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist (NUM_VECTORS=4) with a behavioural ALU,
// stub responders and a whole-run signature model.
module tb_alu_bist;

  localparam int unsigned NV    = 4;
  localparam int unsigned TOTAL = 32 * NV;
  localparam int unsigned MAXC  = TOTAL + 8;
  localparam logic [31:0] SEED  = 32'hACE1_1234;
  localparam int MODE_ALU = 0, MODE_STUB = 1, MODE_KEY = 2;

  logic        clk = 1'b0;
  logic        rst, start;
`ifdef ALU_BIST_ABORT_EN
  logic        abort;
`endif
  logic        busy, done, pass;
  logic [31:0] signature, alu_a, alu_b, alu_c;
  logic [4:0]  alu_op;
  logic        alu_zero;

  int          mode;
  logic [31:0] key;
  logic        fault_on;
  logic [31:0] c_true;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_a [0:TOTAL-1];
  logic [31:0] exp_b [0:TOTAL-1];
  logic [4:0]  exp_op[0:TOTAL-1];
  logic [31:0] obs_a [0:MAXC-1];
  logic [31:0] obs_b [0:MAXC-1];
  logic [4:0]  obs_op[0:MAXC-1];
  logic [31:0] ref_sig;

  always #5 clk = ~clk;

  alu_bist #(.NUM_VECTORS(NV), .LFSR_SEED(SEED), .GOLDEN_SIG(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef ALU_BIST_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_zero  (alu_zero)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    case (op)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a + b;
      5'd3:    return a ^ b;
      5'd4:    return a << b;
      5'd5:    return a >> b;
      5'd6:    return a - b;
      5'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd8:    return 32'($signed(a) >>> b);
      5'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] respond(input int m, input logic [31:0] k,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    if (m == MODE_ALU) return alu_ref(a, b, op);
    if (m == MODE_KEY) return a ^ b ^ k ^ {27'b0, op};
    return 32'd0;
  endfunction

  always_comb begin
    c_true   = respond(mode, key, alu_a, alu_b, alu_op);
    alu_c    = c_true ^ {31'b0, fault_on};
    alu_zero = (mode != MODE_STUB) && (c_true == 32'd0);
  end

  // Multiply-by-x modulo the characteristic polynomial
  function automatic logic [31:0] gstep(input logic [31:0] x);
    return (x << 1) ^ ((x >= 32'h8000_0000) ? 32'h0040_0007 : 32'h0);
  endfunction

  function automatic logic [31:0] model_run(input int m, input logic [31:0] k, input int fault_i);
    logic [31:0] a, b, sig, c;
    logic z;
    int i;
    a = SEED; b = ~SEED; sig = 32'h0;
    for (int op = 0; op < 32; op++) begin
      for (int v = 0; v < int'(NV); v++) begin
        i = op * int'(NV) + v;
        exp_a[i] = a; exp_b[i] = b; exp_op[i] = 5'(op);
        c = respond(m, k, a, b, 5'(op));
        z = (m != MODE_STUB) && (c == 32'h0);
        if (i == fault_i) c = c ^ 32'h1;
        sig = gstep(sig) ^ c ^ {31'b0, z};
        a = gstep(a); b = gstep(b);
      end
    end
    return sig;
  endfunction

  // Called #1 after an edge; leaves the bench #1 after the edge that captured start
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vectors(input int fault_i, input int start_i, input int rst_i,
                             output int ncyc);
    ncyc = 0;
    for (int i = 0; i < int'(MAXC); i++) begin
      if (busy !== 1'b1) break;
      obs_a[i] = alu_a; obs_b[i] = alu_b; obs_op[i] = alu_op;
      ncyc++;
      fault_on = (i == fault_i);
      start    = (i == start_i);
      rst      = (i == rst_i);
      @(posedge clk); #1;
      fault_on = 1'b0; start = 1'b0; rst = 1'b0;
    end
  endtask

  function automatic int trace_errors(input int n);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i] || obs_op[i] !== exp_op[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; fault_on = 1'b0; mode = MODE_ALU; key = '0;
`ifdef ALU_BIST_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({busy, done, pass} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, pass});
    else n_pass++;
    n_checks++;
    if (signature !== 32'h0) $display("FAIL reset_sig got %h want 0", signature);
    else n_pass++;
    n_checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 5'h0)
      $display("FAIL reset_operands got %h %h %h want 0 0 0", alu_a, alu_b, alu_op);
    else n_pass++;
  endtask

  task automatic test_real_alu();
    int ncyc, err;
    mode = MODE_ALU;
    ref_sig = model_run(MODE_ALU, 32'h0, -1);
    repeat ($urandom_range(0, 5)) @(posedge clk);
    #1;
    pulse_start();
    run_vectors(-1, -1, -1, ncyc);
    n_checks++;
    if (obs_a[0] !== 32'hACE1_1234 || obs_b[0] !== 32'h531E_EDCB || obs_op[0] !== 5'd0)
      $display("FAIL first_vector got %h %h %h want ace11234 531eedcb 0", obs_a[0], obs_b[0], obs_op[0]);
    else n_pass++;
    n_checks++;
    if (obs_op[3] !== 5'd0 || obs_op[4] !== 5'd1)
      $display("FAIL op_advance got cyc4=%0d cyc5=%0d want 0 1", obs_op[3], obs_op[4]);
    else n_pass++;
    err = trace_errors(int'(TOTAL));
    n_checks++;
    if (err != 0) $display("FAIL alu_trace got %0d bad vectors want 0", err);
    else n_pass++;
    n_checks++;
    if (ncyc != int'(TOTAL)) $display("FAIL busy_len got %0d want %0d", ncyc, TOTAL);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL done_rise got done=%b busy=%b want 1 0", done, busy);
    else n_pass++;
    n_checks++;
    if (signature !== ref_sig) $display("FAIL alu_sig got %h want %h", signature, ref_sig);
    else n_pass++;
    n_checks++;
    if (pass !== (ref_sig == 32'h0)) $display("FAIL alu_pass got %b want %b", pass, ref_sig == 32'h0);
    else n_pass++;
    n_checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 5'h0)
      $display("FAIL end_operands got %h %h %h want 0 0 0", alu_a, alu_b, alu_op);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || signature !== ref_sig)
      $display("FAIL done_hold got done=%b sig=%h want 1 %h", done, signature, ref_sig);
    else n_pass++;
  endtask

  task automatic test_stub_zero();
    int ncyc;
    mode = MODE_STUB;
    pulse_start();
    run_vectors(-1, -1, -1, ncyc);
    n_checks++;
    if (signature !== 32'h0 || pass !== 1'b1 || done !== 1'b1)
      $display("FAIL stub_zero got sig=%h pass=%b done=%b want 0 1 1", signature, pass, done);
    else n_pass++;
  endtask

  task automatic test_single_fault();
    int ncyc;
    logic [31:0] exp;
    mode = MODE_STUB;
    exp = model_run(MODE_STUB, 32'h0, 5 * int'(NV) + 2);
    pulse_start();
    run_vectors(5 * int'(NV) + 2, -1, -1, ncyc);
    n_checks++;
    if (signature === 32'h0 || signature !== exp)
      $display("FAIL fault_sig got %h want %h (nonzero)", signature, exp);
    else n_pass++;
    n_checks++;
    if (pass !== 1'b0) $display("FAIL fault_pass got %b want 0", pass);
    else n_pass++;
  endtask

  task automatic test_random_keyed();
    int ncyc, fi, err;
    logic [31:0] exp;
    for (int r = 0; r < 3; r++) begin
      mode = MODE_KEY;
      key  = $urandom;
      fi   = (r == 0) ? -1 : int'($urandom_range(TOTAL - 1));
      exp  = model_run(MODE_KEY, key, fi);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      pulse_start();
      run_vectors(fi, -1, -1, ncyc);
      err = trace_errors(int'(TOTAL));
      n_checks++;
      if (signature !== exp || err != 0 || ncyc != int'(TOTAL))
        $display("FAIL keyed_run key=%h fault=%0d got sig=%h bad=%0d len=%0d want %h 0 %0d",
                 key, fi, signature, err, ncyc, exp, TOTAL);
      else n_pass++;
      n_checks++;
      if (pass !== (exp == 32'h0)) $display("FAIL keyed_pass got %b want %b", pass, exp == 32'h0);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    int ncyc;
    mode = MODE_ALU;
    n_checks++;
    if (done !== 1'b1) $display("FAIL done_before_start got %b want 1", done);
    else n_pass++;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0)
      $display("FAIL restart_flags got busy=%b done=%b pass=%b want 1 0 0", busy, done, pass);
    else n_pass++;
    run_vectors(-1, 9, -1, ncyc);
    n_checks++;
    if (ncyc != int'(TOTAL) || signature !== ref_sig)
      $display("FAIL start_in_run got len=%0d sig=%h want %0d %h", ncyc, signature, TOTAL, ref_sig);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int ncyc;
    mode = MODE_ALU;
    pulse_start();
    run_vectors(-1, -1, 49, ncyc);
    n_checks++;
    if (ncyc != 50 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
      $display("FAIL mid_reset got len=%0d busy=%b done=%b pass=%b want 50 0 0 0", ncyc, busy, done, pass);
    else n_pass++;
    n_checks++;
    if (signature !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 5'h0)
      $display("FAIL mid_reset_clear got %h %h %h %h want all 0", signature, alu_a, alu_b, alu_op);
    else n_pass++;
    pulse_start();
    run_vectors(-1, -1, -1, ncyc);
    n_checks++;
    if (signature !== ref_sig || done !== 1'b1)
      $display("FAIL rerun_sig got %h done=%b want %h 1", signature, done, ref_sig);
    else n_pass++;
  endtask

`ifdef ALU_BIST_ABORT_EN
  task automatic test_abort();
    pulse_start();
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
      $display("FAIL abort_flags got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
    else n_pass++;
    n_checks++;
    if (signature !== ref_sig || alu_a !== 32'h0 || alu_op !== 5'h0)
      $display("FAIL abort_hold got sig=%h a=%h op=%h want %h 0 0", signature, alu_a, alu_op, ref_sig);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_real_alu();
    test_stub_zero();
    test_single_fault();
    test_random_keyed();
    test_start_ignored();
    test_reset_mid_run();
`ifdef ALU_BIST_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
